// File: rtl/shift_pkg.sv
// Shared encodings and small decode helpers for the parametrised shift register.
package shift_pkg;

    localparam logic [2:0] MODO_SHL  = 3'b000;
    localparam logic [2:0] MODO_ROT  = 3'b001;
    localparam logic [2:0] MODO_LOAD = 3'b010;
    localparam logic [2:0] MODO_HOLD = 3'b011;
    localparam logic [2:0] MODO_ASH  = 3'b100;
    localparam logic [2:0] MODO_CNT  = 3'b101;

    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Only operations that make sense to repeat may start a burst.
    function automatic logic burst_ok(input logic [2:0] m);
        return (m == MODO_SHL) || (m == MODO_ROT) || (m == MODO_ASH) || (m == MODO_CNT);
    endfunction

    // Hold plus the two reserved codes leave both Q and S_OUT untouched.
    function automatic logic is_hold(input logic [2:0] m);
        return (m == MODO_HOLD) || (m[2:1] == 2'b11);
    endfunction

endpackage

// File: rtl/shift_op_unit.sv
// Combinational next-state logic for one shift/rotate/load/count operation.
module shift_op_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic [2:0]       i_modo,
    input  logic             i_dir,
    input  logic             i_s_in,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_next_q,
    output logic             o_next_sout
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic signed [WIDTH-1:0] w_q_s;
    assign w_q_s = i_q;

    always_comb begin
        o_next_q    = i_q;
        o_next_sout = 1'b0;
        case (i_modo)
            MODO_SHL: begin
                if (i_dir == DIR_RIGHT) begin
                    o_next_q    = {i_s_in, i_q[WIDTH-1:1]};
                    o_next_sout = i_q[0];
                end else begin
                    o_next_q    = {i_q[WIDTH-2:0], i_s_in};
                    o_next_sout = i_q[WIDTH-1];
                end
            end
            MODO_ROT: begin
                if (i_dir == DIR_RIGHT) begin
                    o_next_q    = {i_q[0], i_q[WIDTH-1:1]};
                    o_next_sout = i_q[0];
                end else begin
                    o_next_q    = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
                    o_next_sout = i_q[WIDTH-1];
                end
            end
            MODO_LOAD: o_next_q = i_d;
            MODO_ASH: begin
                if (i_dir == DIR_RIGHT) begin
                    o_next_q    = w_q_s >>> 1;
                    o_next_sout = i_q[0];
                end else begin
                    o_next_q    = {i_q[WIDTH-2:0], 1'b0};
                    o_next_sout = i_q[WIDTH-1];
                end
            end
            // Carry/borrow flags the wrap: up from all-ones, down from zero.
            MODO_CNT: begin
                if (i_dir == DIR_RIGHT) begin
                    o_next_q    = i_q - ONE;
                    o_next_sout = ~|i_q;
                end else begin
                    o_next_q    = i_q + ONE;
                    o_next_sout = &i_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/param_shift_register.sv
// WIDTH-bit universal shift register / counter with a START/BUSY/DONE burst engine.
module param_shift_register
    import shift_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ENB,
    input  logic              DIR,
    input  logic              S_IN,
    input  logic [2:0]        MODO,
    input  logic [WIDTH-1:0]  D,
    input  logic              START,
    input  logic [STEP_W-1:0] STEPS,
    output logic [WIDTH-1:0]  Q,
    output logic              S_OUT,
    output logic              BUSY,
    output logic              DONE
);

    localparam logic [STEP_W-1:0] CNT_ONE = STEP_W'(1);

    state_t            r_state;
    logic [STEP_W-1:0] r_cnt;
    logic [2:0]        r_modo;
    logic              r_dir;
    logic [WIDTH-1:0]  r_q;
    logic              r_sout;
    logic              r_done;

    logic [2:0]        w_modo;
    logic              w_dir;
    logic              w_accept;
    logic [WIDTH-1:0]  w_next_q;
    logic              w_next_sout;

    // A running burst replays its captured operation; live MODO/DIR are ignored.
    assign w_modo   = (r_state == ST_RUN) ? r_modo : MODO;
    assign w_dir    = (r_state == ST_RUN) ? r_dir  : DIR;
    assign w_accept = START && (r_state == ST_IDLE) && burst_ok(MODO);

    shift_op_unit #(
        .WIDTH(WIDTH)
    ) u_op (
        .i_q        (r_q),
        .i_modo     (w_modo),
        .i_dir      (w_dir),
        .i_s_in     (S_IN),
        .i_d        (D),
        .o_next_q   (w_next_q),
        .o_next_sout(w_next_sout)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_q     <= '0;
            r_sout  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // DONE is a single-edge pulse even while ENB holds everything else.
            r_done <= 1'b0;
            if (ENB) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            r_modo <= MODO;
                            r_dir  <= DIR;
                            r_cnt  <= STEPS;
                            if (STEPS != '0) r_state <= ST_RUN;
                            else             r_done  <= 1'b1;
                        end else begin
                            r_q <= w_next_q;
                            if (!is_hold(MODO)) r_sout <= w_next_sout;
                        end
                    end
                    ST_RUN: begin
                        r_q    <= w_next_q;
                        r_sout <= w_next_sout;
                        r_cnt  <= r_cnt - CNT_ONE;
                        if (r_cnt == CNT_ONE) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign Q     = r_q;
    assign S_OUT = r_sout;
    assign BUSY  = (r_state == ST_RUN);
    assign DONE  = r_done;

endmodule

// File: tb/tb_param_shift_register.sv
// Scoreboard bench for param_shift_register at WIDTH=4: directed scenarios plus a modelled random run.
module tb_param_shift_register;
    import shift_pkg::*;

    localparam int W = 4;
    localparam logic L = 1'b0;
    localparam logic H = 1'b1;

    typedef struct packed {
        logic       rst;
        logic       enb;
        logic [2:0] modo;
        logic       dir;
        logic       sin;
        logic [3:0] d;
        logic       start;
        logic [3:0] steps;
    } stim_t;

    typedef struct packed {
        logic [3:0] q;
        logic       so;
        logic       busy;
        logic       done;
    } exp_t;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         ENB = 1'b0;
    logic         DIR = 1'b0;
    logic         S_IN = 1'b0;
    logic [2:0]   MODO = 3'b000;
    logic [W-1:0] D = '0;
    logic         START = 1'b0;
    logic [3:0]   STEPS = '0;
    logic [W-1:0] Q;
    logic         S_OUT;
    logic         BUSY;
    logic         DONE;

    int vectors = 0;
    int miscompares = 0;
    exp_t sb[$];

    // Reference model state for the random run
    logic [3:0] m_q, m_cnt;
    logic       m_so, m_busy, m_done, m_dir;
    logic [2:0] m_mode;

    param_shift_register #(.WIDTH(W), .STEP_W(4)) dut (
        .CLK(CLK), .RST(RST), .ENB(ENB), .DIR(DIR), .S_IN(S_IN), .MODO(MODO),
        .D(D), .START(START), .STEPS(STEPS), .Q(Q), .S_OUT(S_OUT), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic stim_t mk(input logic rst, enb, input logic [2:0] modo,
                                 input logic dir, sin, input logic [3:0] d,
                                 input logic start, input logic [3:0] steps);
        mk = {rst, enb, modo, dir, sin, d, start, steps};
    endfunction

    task automatic tick(input stim_t s);
        RST = s.rst; ENB = s.enb; MODO = s.modo; DIR = s.dir; S_IN = s.sin;
        D = s.d; START = s.start; STEPS = s.steps;
        @(posedge CLK);
        #1;
    endtask

    task automatic model_op(input logic [2:0] op, input logic dir, sin, input logic [3:0] d);
        logic [3:0] q;
        q = m_q;
        case (op)
            3'b000: begin m_so = dir ? q[0] : q[3]; m_q = dir ? {sin, q[3:1]} : {q[2:0], sin}; end
            3'b001: begin m_so = dir ? q[0] : q[3]; m_q = dir ? {q[0], q[3:1]} : {q[2:0], q[3]}; end
            3'b010: begin m_q = d; m_so = 1'b0; end
            3'b100: begin m_so = dir ? q[0] : q[3]; m_q = dir ? {q[3], q[3:1]} : {q[2:0], 1'b0}; end
            3'b101: begin
                m_q  = dir ? q - 4'd1 : q + 4'd1;
                m_so = dir ? (q == 4'd0) : (q == 4'hF);
            end
            default: ;
        endcase
    endtask

    task automatic model_step(input stim_t s);
        if (s.rst) begin
            m_q = '0; m_so = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_cnt = '0;
            return;
        end
        m_done = 1'b0;
        if (!s.enb) return;
        if (m_busy) begin
            model_op(m_mode, m_dir, s.sin, s.d);
            m_cnt = m_cnt - 4'd1;
            if (m_cnt == 4'd0) begin m_busy = 1'b0; m_done = 1'b1; end
        end else if (s.start && (s.modo == 3'b000 || s.modo == 3'b001 ||
                                 s.modo == 3'b100 || s.modo == 3'b101)) begin
            m_mode = s.modo; m_dir = s.dir; m_cnt = s.steps;
            if (s.steps != 4'd0) m_busy = 1'b1;
            else                 m_done = 1'b1;
        end else begin
            model_op(s.modo, s.dir, s.sin, s.d);
        end
    endtask

    task automatic test_reset();
        stim_t st[3]; exp_t ex[3]; exp_t e;
        st = '{mk(H, H, MODO_SHL, L, H, 4'hF, H, 4'd3),
               mk(H, L, MODO_LOAD, L, L, 4'hF, L, 4'd0),
               mk(L, L, MODO_LOAD, L, L, 4'hF, L, 4'd0)};
        ex = '{7'b0000_0_0_0, 7'b0000_0_0_0, 7'b0000_0_0_0};
        foreach (st[i]) begin
            sb.push_back(ex[i]);
            tick(st[i]);
            e = sb.pop_front();
            vectors++;
            if ({Q, S_OUT, BUSY, DONE} !== e) begin
                miscompares++;
                $display("FAIL reset[%0d]: got Q=%b S_OUT=%b BUSY=%b DONE=%b, want Q=%b S_OUT=%b BUSY=%b DONE=%b",
                         i, Q, S_OUT, BUSY, DONE, e.q, e.so, e.busy, e.done);
            end
        end
    endtask

    task automatic test_shift_right();
        stim_t st[6]; exp_t ex[6]; exp_t e;
        st = '{mk(L, H, MODO_LOAD, L, L, 4'b1000, L, 4'd0),
               mk(L, H, MODO_SHL, H, L, 4'b0000, L, 4'd0),
               mk(L, H, MODO_SHL, H, L, 4'b0000, L, 4'd0),
               mk(L, H, MODO_SHL, H, L, 4'b0000, L, 4'd0),
               mk(L, H, MODO_SHL, H, L, 4'b0000, L, 4'd0),
               mk(L, H, MODO_SHL, H, L, 4'b0000, L, 4'd0)};
        ex = '{7'b1000_0_0_0, 7'b0100_0_0_0, 7'b0010_0_0_0,
               7'b0001_0_0_0, 7'b0000_1_0_0, 7'b0000_0_0_0};
        foreach (st[i]) begin
            sb.push_back(ex[i]);
            tick(st[i]);
            e = sb.pop_front();
            vectors++;
            if ({Q, S_OUT, BUSY, DONE} !== e) begin
                miscompares++;
                $display("FAIL shift_right[%0d]: got Q=%b S_OUT=%b BUSY=%b DONE=%b, want Q=%b S_OUT=%b BUSY=%b DONE=%b",
                         i, Q, S_OUT, BUSY, DONE, e.q, e.so, e.busy, e.done);
            end
        end
    endtask

    task automatic test_rotate_ash();
        stim_t st[7]; exp_t ex[7]; exp_t e;
        st = '{mk(L, H, MODO_LOAD, L, L, 4'b1001, L, 4'd0),
               mk(L, H, MODO_ROT,  L, L, 4'b0000, L, 4'd0),
               mk(L, H, MODO_ROT,  L, L, 4'b0000, L, 4'd0),
               mk(L, H, MODO_LOAD, L, L, 4'b1000, L, 4'd0),
               mk(L, H, MODO_ASH,  H, L, 4'b0000, L, 4'd0),
               mk(L, H, MODO_ASH,  L, H, 4'b0000, L, 4'd0),
               mk(L, H, MODO_SHL,  L, H, 4'b0000, L, 4'd0)};
        ex = '{7'b1001_0_0_0, 7'b0011_1_0_0, 7'b0110_0_0_0, 7'b1000_0_0_0,
               7'b1100_0_0_0, 7'b1000_1_0_0, 7'b0001_1_0_0};
        foreach (st[i]) begin
            sb.push_back(ex[i]);
            tick(st[i]);
            e = sb.pop_front();
            vectors++;
            if ({Q, S_OUT, BUSY, DONE} !== e) begin
                miscompares++;
                $display("FAIL rotate_ash[%0d]: got Q=%b S_OUT=%b BUSY=%b DONE=%b, want Q=%b S_OUT=%b BUSY=%b DONE=%b",
                         i, Q, S_OUT, BUSY, DONE, e.q, e.so, e.busy, e.done);
            end
        end
    endtask

    task automatic test_count();
        stim_t st[7]; exp_t ex[7]; exp_t e;
        st = '{mk(L, H, MODO_LOAD, L, L, 4'b1110, L, 4'd0),
               mk(L, H, MODO_CNT,  L, L, 4'b0000, L, 4'd0),
               mk(L, H, MODO_CNT,  L, L, 4'b0000, L, 4'd0),
               mk(L, H, MODO_HOLD, L, H, 4'b0101, L, 4'd0),
               mk(L, H, 3'b110,    H, H, 4'b0101, L, 4'd0),
               mk(L, H, MODO_CNT,  H, L, 4'b0000, L, 4'd0),
               mk(L, H, MODO_CNT,  H, L, 4'b0000, L, 4'd0)};
        ex = '{7'b1110_0_0_0, 7'b1111_0_0_0, 7'b0000_1_0_0, 7'b0000_1_0_0,
               7'b0000_1_0_0, 7'b1111_1_0_0, 7'b1110_0_0_0};
        foreach (st[i]) begin
            sb.push_back(ex[i]);
            tick(st[i]);
            e = sb.pop_front();
            vectors++;
            if ({Q, S_OUT, BUSY, DONE} !== e) begin
                miscompares++;
                $display("FAIL count[%0d]: got Q=%b S_OUT=%b BUSY=%b DONE=%b, want Q=%b S_OUT=%b BUSY=%b DONE=%b",
                         i, Q, S_OUT, BUSY, DONE, e.q, e.so, e.busy, e.done);
            end
        end
    endtask

    task automatic test_burst();
        stim_t st[6]; exp_t ex[6]; exp_t e;
        st = '{mk(L, H, MODO_LOAD, L, L, 4'b0001, L, 4'd0),
               mk(L, H, MODO_SHL,  L, L, 4'b0000, H, 4'd3),
               mk(L, H, MODO_LOAD, H, L, 4'b1111, L, 4'd0),
               mk(L, H, MODO_HOLD, H, L, 4'b1111, L, 4'd0),
               mk(L, H, MODO_CNT,  H, L, 4'b1111, L, 4'd0),
               mk(L, H, MODO_HOLD, L, L, 4'b0000, L, 4'd0)};
        ex = '{7'b0001_0_0_0, 7'b0001_0_1_0, 7'b0010_0_1_0,
               7'b0100_0_1_0, 7'b1000_0_0_1, 7'b1000_0_0_0};
        foreach (st[i]) begin
            sb.push_back(ex[i]);
            tick(st[i]);
            e = sb.pop_front();
            vectors++;
            if ({Q, S_OUT, BUSY, DONE} !== e) begin
                miscompares++;
                $display("FAIL burst[%0d]: got Q=%b S_OUT=%b BUSY=%b DONE=%b, want Q=%b S_OUT=%b BUSY=%b DONE=%b",
                         i, Q, S_OUT, BUSY, DONE, e.q, e.so, e.busy, e.done);
            end
        end
    endtask

    task automatic test_pause_reset();
        stim_t st[12]; exp_t ex[12]; exp_t e;
        st = '{mk(L, H, MODO_LOAD, L, L, 4'b0001, L, 4'd0),
               mk(L, H, MODO_ROT,  L, L, 4'b0000, H, 4'd4),
               mk(L, H, MODO_HOLD, L, L, 4'b0000, L, 4'd0),
               mk(L, L, MODO_LOAD, L, L, 4'b1111, H, 4'd2),
               mk(L, L, MODO_LOAD, L, L, 4'b1111, H, 4'd2),
               mk(L, H, MODO_HOLD, L, L, 4'b0000, L, 4'd0),
               mk(L, H, MODO_HOLD, L, L, 4'b0000, L, 4'd0),
               mk(L, H, MODO_HOLD, L, L, 4'b0000, L, 4'd0),
               mk(L, H, MODO_LOAD, L, L, 4'b0110, L, 4'd0),
               mk(L, H, MODO_SHL,  H, H, 4'b0000, H, 4'd5),
               mk(L, H, MODO_HOLD, L, H, 4'b0000, L, 4'd0),
               mk(H, H, MODO_HOLD, L, H, 4'b0000, L, 4'd0)};
        ex = '{7'b0001_0_0_0, 7'b0001_0_1_0, 7'b0010_0_1_0, 7'b0010_0_1_0,
               7'b0010_0_1_0, 7'b0100_0_1_0, 7'b1000_0_1_0, 7'b0001_1_0_1,
               7'b0110_0_0_0, 7'b0110_0_1_0, 7'b1011_0_1_0, 7'b0000_0_0_0};
        foreach (st[i]) begin
            sb.push_back(ex[i]);
            tick(st[i]);
            e = sb.pop_front();
            vectors++;
            if ({Q, S_OUT, BUSY, DONE} !== e) begin
                miscompares++;
                $display("FAIL pause_reset[%0d]: got Q=%b S_OUT=%b BUSY=%b DONE=%b, want Q=%b S_OUT=%b BUSY=%b DONE=%b",
                         i, Q, S_OUT, BUSY, DONE, e.q, e.so, e.busy, e.done);
            end
        end
        // After a reset-aborted burst no DONE may ever appear.
        sb.push_back(7'b0000_0_0_0);
        tick(mk(L, H, MODO_HOLD, L, L, 4'b0000, L, 4'd0));
        e = sb.pop_front();
        vectors++;
        if ({Q, S_OUT, BUSY, DONE} !== e) begin
            miscompares++;
            $display("FAIL abort_no_done: got Q=%b S_OUT=%b BUSY=%b DONE=%b, want Q=%b S_OUT=%b BUSY=%b DONE=%b",
                     Q, S_OUT, BUSY, DONE, e.q, e.so, e.busy, e.done);
        end
    endtask

    task automatic test_start_edge();
        stim_t st[10]; exp_t ex[10]; exp_t e;
        st = '{mk(L, H, MODO_LOAD, L, L, 4'b0101, L, 4'd0),
               mk(L, H, MODO_SHL,  L, H, 4'b0000, H, 4'd0),
               mk(L, H, MODO_HOLD, L, L, 4'b0000, L, 4'd0),
               mk(L, H, MODO_LOAD, L, L, 4'b1010, H, 4'd3),
               mk(L, H, MODO_HOLD, L, L, 4'b0000, L, 4'd0),
               mk(L, H, MODO_CNT,  L, L, 4'b0000, H, 4'd2),
               mk(L, H, MODO_SHL,  H, H, 4'b0000, H, 4'd9),
               mk(L, H, MODO_SHL,  H, H, 4'b0000, H, 4'd9),
               mk(L, L, MODO_HOLD, L, L, 4'b0000, L, 4'd0),
               mk(L, H, MODO_HOLD, L, L, 4'b0000, L, 4'd0)};
        ex = '{7'b0101_0_0_0, 7'b0101_0_0_1, 7'b0101_0_0_0, 7'b1010_0_0_0,
               7'b1010_0_0_0, 7'b1010_0_1_0, 7'b1011_0_1_0, 7'b1100_0_0_1,
               7'b1100_0_0_0, 7'b1100_0_0_0};
        foreach (st[i]) begin
            sb.push_back(ex[i]);
            tick(st[i]);
            e = sb.pop_front();
            vectors++;
            if ({Q, S_OUT, BUSY, DONE} !== e) begin
                miscompares++;
                $display("FAIL start_edge[%0d]: got Q=%b S_OUT=%b BUSY=%b DONE=%b, want Q=%b S_OUT=%b BUSY=%b DONE=%b",
                         i, Q, S_OUT, BUSY, DONE, e.q, e.so, e.busy, e.done);
            end
        end
    endtask

    task automatic test_random();
        stim_t s; exp_t e;
        for (int i = 0; i < 300; i++) begin
            s = mk((i == 0) || ($urandom_range(0, 59) == 0),
                   $urandom_range(0, 4) != 0,
                   3'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 15)),
                   $urandom_range(0, 2) == 0,
                   4'($urandom_range(0, 5)));
            model_step(s);
            sb.push_back({m_q, m_so, m_busy, m_done});
            tick(s);
            e = sb.pop_front();
            vectors++;
            if ({Q, S_OUT, BUSY, DONE} !== e) begin
                miscompares++;
                $display("FAIL random[%0d]: got Q=%b S_OUT=%b BUSY=%b DONE=%b, want Q=%b S_OUT=%b BUSY=%b DONE=%b",
                         i, Q, S_OUT, BUSY, DONE, e.q, e.so, e.busy, e.done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_shift_right();
        test_rotate_ash();
        test_count();
        test_burst();
        test_pause_reset();
        test_start_edge();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/param_shift_register.md
Name: param_shift_register

Overview:
- Parametrised successor to the 4-bit universal shift register.
- WIDTH-bit register with these operations: logical shift, rotate, arithmetic shift, parallel load, hold and up/down binary count.
- Adds a multi-step burst engine with a START/BUSY/DONE handshake.
- Drives the datapath register slice and the counter/shifter test benches in this directory.

Parameters:
- WIDTH, 8, register width in bits (must be 2 or more).
- STEP_W, 4, width of STEPS; a burst runs at most 2^STEP_W-1 steps.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous reset, active-high.
- ENB  input  1  clock enable; when 0, all state including burst progress is frozen.
- DIR  input  1  shift: 1=right (towards bit 0), 0=left. Count: 1=down, 0=up.
- S_IN  input  1  serial input bit for logical shifts.
- MODO  input  3  operation select (see Behaviour).
- D  input  WIDTH  parallel load data.
- START  input  1  request a burst of STEPS operations in the current MODO/DIR.
- STEPS  input  STEP_W  burst length.
- Q  output  WIDTH  register contents.
- S_OUT  output  1  bit shifted out, or carry/borrow flag in count mode (registered).
- BUSY  output  1  burst in progress.
- DONE  output  1  one-cycle pulse after the last burst step.

Behaviour:
- Reset: RST=1 at an edge sets Q=0, S_OUT=0, BUSY=0, DONE=0, step counter=0. RST takes priority over ENB and START. A reset during a burst aborts it and no DONE is produced.
- MODO encoding:
  - 000: logical shift. Right: Q <= {S_IN, Q[W-1:1]}, S_OUT <= Q[0]. Left: Q <= {Q[W-2:0], S_IN}, S_OUT <= Q[W-1].
  - 001: rotate. The wrapped bit is also copied to S_OUT.
  - 010: parallel load. Q <= D, S_OUT <= 0.
  - 011: hold. Q and S_OUT unchanged.
  - 100: arithmetic shift. Right replicates Q[W-1]; left inserts 0. S_OUT is the bit shifted out.
  - 101: count. Q <= Q±1 modulo 2^WIDTH. S_OUT <= 1 only on the cycle Q wraps (up from all-ones, or down from 0), otherwise 0.
  - 110, 111: reserved, behave as hold.
- Idle operation (BUSY=0, no START accepted): each edge with ENB=1 applies MODO once.
- Burst acceptance:
  - START is accepted when ENB=1, BUSY=0 and MODO is in {000, 001, 100, 101}.
  - On the accepting edge, MODO and DIR are captured, counter <= STEPS, Q is unchanged, and BUSY <= 1 if STEPS≠0.
  - START with STEPS=0: DONE pulses on the next edge, BUSY stays 0, Q unchanged.
  - START with MODO in {010, 011, 110, 111}: ignored; the idle operation is applied instead.
- Burst progress:
  - Each ENB=1 edge while BUSY=1 performs one step of the captured operation and decrements the counter. S_IN is sampled live on each step.
  - Live MODO/DIR are ignored while BUSY=1.
  - START while BUSY=1 is ignored.
- Burst completion: the edge performing the last step sets BUSY <= 0 and DONE <= 1. DONE clears on the following edge.
- Timing: a burst of N steps holds BUSY high for N enabled cycles. The final Q is visible after the (N+1)th enabled edge counting from the START edge.
- ENB=0 in the middle of a burst pauses it. BUSY stays 1; a DONE that has already been raised still clears on the next edge.
- Widths: all arithmetic is modulo 2^WIDTH. There is no saturation.

Decomposition:
- Package shift_pkg:
  - MODO encodings as localparams: MODO_SHL, MODO_ROT, MODO_LOAD, MODO_HOLD, MODO_ASH, MODO_CNT.
  - DIR_RIGHT=1.
- Sub-module shift_op_unit: purely combinational.
  - Inputs: Q, MODO, DIR, S_IN, D.
  - Outputs: next_q, next_sout.
- The top level holds the registers and the burst counter FSM (IDLE/RUN, with a DONE pulse register).

Test Plan:
1. WIDTH=4. Load D=1000 with MODO=010, then MODO=000, DIR=1, S_IN=0 for 5 edges -> Q=0100, 0010, 0001, 0000, 0000; S_OUT=0, 0, 0, 1, 0.
2. Load 1001, then MODO=001, DIR=0 for 2 edges -> Q=0011, S_OUT=1, then Q=0110, S_OUT=0. MODO=100, DIR=1 from 1000 -> Q=1100.
3. MODO=101, DIR=0 from 1110 -> Q=1111, S_OUT=0, then Q=0000, S_OUT=1. DIR=1 from 0000 -> Q=1111, S_OUT=1.
4. Load 0001, then START with STEPS=3, MODO=000, DIR=0, S_IN=0 -> BUSY high for 3 cycles. Q=0010, 0100, 1000. DONE pulses with Q=1000. MODO changed mid-burst has no effect.
5. Burst STEPS=4 with ENB=0 for 2 cycles mid-burst -> BUSY stays high for 6 cycles and Q is frozen during the gap. RST mid-burst -> Q=0, BUSY=0, no DONE.
6. START with STEPS=0 -> single DONE pulse, Q unchanged. START with MODO=010 -> treated as a load, no BUSY or DONE. START while BUSY -> ignored.
